key_step_ctrl: RTL and testbench
================================

KEY_STEP_CTRL -- requirements
Module: key_step_ctrl

Interface
REQ-001 SHALL have parameter DB_CYC, default 1_000_000, meaning consecutive stable cycles required to accept a key level (20 ms at 50 MHz).
REQ-002 SHALL have parameter IDLE_CYC, default 500_000_000, meaning cycles without an accepted press before the display blanks.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-005 SHALL have port key_up_n, input, 1 bit: raw asynchronous up button, active-low.
REQ-006 SHALL have port key_dn_n, input, 1 bit: raw asynchronous down button, active-low.
REQ-007 SHALL have port seg_data, output, 3 bits: registered display code to the segment decoder; 0..6 select digits 1..7, 7 selects blank.
REQ-008 SHALL have port step_pulse, output, 1 bit: one-cycle strobe asserted in the cycle seg_data takes a new digit value.

Function
REQ-009 SHALL pass each key through a two-flop synchronizer before any other logic.
REQ-010 SHALL accept a new debounced level only after the synchronized input differs from the current debounced level for DB_CYC consecutive cycles; any bounce back clears the count.
REQ-011 SHALL generate a one-cycle press event on each accepted 1->0 debounced transition; release transitions SHALL generate no event.
REQ-012 SHALL hold an internal digit register cnt in the range 0..6, never 7.
REQ-013 SHALL, in state SHOW on an up event alone: cnt 6 -> 0, otherwise cnt+1.
REQ-014 SHALL, in state SHOW on a down event alone: cnt 0 -> 6, otherwise cnt-1.
REQ-015 SHALL ignore up and down events that occur in the same cycle: no cnt change, no step_pulse, idle counter cleared.
REQ-016 SHALL update seg_data and assert step_pulse in the cycle after the press event (latency from raw edge to seg_data = 2 + DB_CYC + 1 cycles).
REQ-017 SHALL implement an FSM with states SHOW (seg_data = cnt) and BLANK (seg_data = 7).
REQ-018 SHALL count cycles in SHOW with no press event, clear the counter on any event, and move SHOW -> BLANK when the count reaches IDLE_CYC-1.
REQ-019 SHALL, on any press event in BLANK, go to SHOW with cnt unchanged and no step_pulse (a wake-only press).
REQ-020 SHALL keep a key held indefinitely as a single event; no auto-repeat.

Reset
REQ-021 SHALL, on rst high at a clk edge: set cnt=0, FSM=SHOW, seg_data=0, step_pulse=0, idle and debounce counters=0, synchronizer flops and debounced levels=1 (released).
REQ-022 SHALL give rst priority over every event in the same cycle; a press whose debounce was in progress at reset SHALL be discarded.

Structure
REQ-023 SHALL place the constants SEG_BLANK=3'd7 and SEG_MAX=3'd6 and the FSM state typedef in the shared package led_pkg, which the segment decoder also uses.
REQ-024 SHALL implement synchronizer, debounce and press-event logic in sub-module key_debounce, instantiated once per key.

Verification (DB_CYC=4, IDLE_CYC=50)
REQ-025 Stimulus: reset, then one clean up press. Required response: seg_data 0 -> 1 exactly 7 cycles after the raw edge, step_pulse high for 1 cycle.
REQ-026 Stimulus: seven up presses from reset. Required response: seg_data steps 1,2,3,4,5,6,0; then one down press gives 6.
REQ-027 Stimulus: an up press with a 2-cycle low glitch followed by a 3-cycle bounce. Required response: no change; only the final stable 4-cycle low yields a single step.
REQ-028 Stimulus: up and down events in the same cycle. Required response: seg_data unchanged, step_pulse stays 0.
REQ-029 Stimulus: 50 idle cycles at cnt=3. Required response: seg_data=7; the next down press gives seg_data=3 with no step_pulse; the following down press gives 2.
REQ-030 Stimulus: rst asserted mid-debounce at cnt=5. Required response: the next cycle has seg_data=0 and step_pulse=0; the interrupted press produces no event.

Source files
------------

// File: rtl/led_pkg.sv
// Shared display constants, FSM state type and digit wrap helpers for the
// step controller and the segment decoder.
package led_pkg;

  localparam logic [2:0] SEG_BLANK = 3'd7;
  localparam logic [2:0] SEG_MAX   = 3'd6;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } led_state_e;

  function automatic logic [2:0] digit_up(input logic [2:0] d);
    return (d == SEG_MAX) ? 3'd0 : d + 3'd1;
  endfunction

  function automatic logic [2:0] digit_dn(input logic [2:0] d);
    return (d == 3'd0) ? SEG_MAX : d - 3'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, consecutive-cycle debounce and registered press
// strobe for one active-low push button.
module key_debounce #(
  parameter int unsigned DB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_lvl;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  logic w_diff;
  logic w_done;

  assign w_diff = (r_sync2 != r_lvl);
  assign w_done = w_diff && (r_cnt == CW'(DB_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_lvl   <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      // Strobe only on an accepted fall; releases update the level silently.
      r_press <= w_done && !r_sync2;
      if (w_done) begin
        r_lvl <= r_sync2;
        r_cnt <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/key_step_ctrl.sv
// Up/down key stepper over digits 1..7 with idle blanking; a press while
// blank only wakes the display.
module key_step_ctrl
  import led_pkg::*;
#(
  parameter int unsigned DB_CYC   = 1_000_000,
  parameter int unsigned IDLE_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  output logic [2:0] seg_data,
  output logic       step_pulse
);

  localparam int unsigned IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;

  logic w_up;
  logic w_dn;

  key_debounce #(.DB_CYC(DB_CYC)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (key_up_n),
    .o_press (w_up)
  );

  key_debounce #(.DB_CYC(DB_CYC)) u_db_dn (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (key_dn_n),
    .o_press (w_dn)
  );

  led_state_e    r_state;
  logic [2:0]    r_cnt;
  logic [IW-1:0] r_idle;
  logic [2:0]    r_seg;
  logic          r_step;

  led_state_e    w_state_nxt;
  logic [2:0]    w_cnt_nxt;
  logic [IW-1:0] w_idle_nxt;
  logic [2:0]    w_seg_nxt;
  logic          w_step_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SHOW;
      r_cnt   <= '0;
      r_idle  <= '0;
      r_seg   <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idle  <= w_idle_nxt;
      r_seg   <= w_seg_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idle_nxt  = r_idle;
    case (r_state)
      SHOW: begin
        if (w_up || w_dn) begin
          w_idle_nxt = '0;
          if (w_up && !w_dn) begin
            w_cnt_nxt = digit_up(r_cnt);
          end else if (w_dn && !w_up) begin
            w_cnt_nxt = digit_dn(r_cnt);
          end
        end else if (r_idle == IW'(IDLE_CYC - 1)) begin
          w_state_nxt = BLANK;
          w_idle_nxt  = '0;
        end else begin
          w_idle_nxt = r_idle + IW'(1);
        end
      end
      BLANK: begin
        if (w_up || w_dn) begin
          w_state_nxt = SHOW;
        end
      end
      default: w_state_nxt = SHOW;
    endcase
  end

  // Display code is registered from the next-state values so it lands together with step_pulse.
  always_comb begin
    w_seg_nxt  = (w_state_nxt == SHOW) ? w_cnt_nxt : SEG_BLANK;
    w_step_nxt = (r_state == SHOW) && (w_up != w_dn);
  end

  assign seg_data   = r_seg;
  assign step_pulse = r_step;

endmodule

// File: tb/tb_key_step_ctrl.sv
// Bench for key_step_ctrl: directed scenarios plus random key activity,
// every cycle compared against a behavioural model of the key rules.
module tb_key_step_ctrl;

  localparam int unsigned DB   = 4;
  localparam int unsigned IDLE = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic [2:0] seg_data;
  logic       step_pulse;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_steps  = 0;

  key_step_ctrl #(.DB_CYC(DB), .IDLE_CYC(IDLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_up_n   (key_up_n),
    .key_dn_n   (key_dn_n),
    .seg_data   (seg_data),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: raw keys seen two edges late, a level is accepted after
  // DB consecutive differing samples, and a fall becomes an event acted on one edge later.
  int unsigned m_cnt, m_idle;
  int unsigned m_run [2];
  bit          m_blank, m_step, chk_en;
  bit          m_lvl [2];
  bit          m_p1 [2];
  bit          m_p2 [2];
  bit          m_ev [2];
  logic [2:0]  m_seg;

  initial chk_en = 1'b0;

  always @(posedge clk) begin
    bit raw [2];
    raw[0] = key_up_n;
    raw[1] = key_dn_n;
    if (rst) begin
      m_cnt = 0; m_idle = 0; m_blank = 0; m_step = 0; m_seg = 3'd0;
      for (int k = 0; k < 2; k++) begin
        m_run[k] = 0; m_lvl[k] = 1; m_p1[k] = 1; m_p2[k] = 1; m_ev[k] = 0;
      end
      chk_en = 1'b1;
    end else begin
      m_step = 0;
      if (m_ev[0] || m_ev[1]) begin
        if (!m_blank && (m_ev[0] != m_ev[1])) begin
          m_cnt  = m_ev[0] ? (m_cnt + 1) % 7 : (m_cnt + 6) % 7;
          m_step = 1;
        end
        m_blank = 0;
        m_idle  = 0;
      end else if (!m_blank) begin
        if (m_idle == IDLE - 1) begin
          m_blank = 1;
          m_idle  = 0;
        end else begin
          m_idle++;
        end
      end
      m_seg = m_blank ? 3'd7 : 3'(m_cnt);
      for (int k = 0; k < 2; k++) begin
        m_ev[k] = 0;
        if (m_p2[k] != m_lvl[k]) m_run[k]++;
        else m_run[k] = 0;
        if (m_run[k] == DB) begin
          m_lvl[k] = m_p2[k];
          m_run[k] = 0;
          m_ev[k]  = !m_lvl[k];
        end
        m_p2[k] = m_p1[k];
        m_p1[k] = raw[k];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("seg_model", seg_data, m_seg);
      check_eq("step_model", step_pulse, m_step);
      if (step_pulse === 1'b1) n_steps++;
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic drive(input bit up_n, input bit dn_n, input int unsigned cyc);
    key_up_n = up_n;
    key_dn_n = dn_n;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic press(input bit up_n, input bit dn_n);
    drive(up_n, dn_n, DB + 4);
    drive(1'b1, 1'b1, DB + 6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int unsigned exp_seq [7] = '{1, 2, 3, 4, 5, 6, 0};

  initial begin
    int unsigned n;
    int unsigned s0;
    @(negedge clk);
    do_reset();
    check_eq("rst_seg", seg_data, 0);
    check_eq("rst_step", step_pulse, 0);

    // single clean up press: latency from raw edge
    key_up_n = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (seg_data !== 3'd1 && n < 20);
    check_eq("latency", n, 7);
    check_eq("lat_step_hi", step_pulse, 1);
    @(posedge clk); #1;
    check_eq("lat_step_lo", step_pulse, 0);
    @(negedge clk);
    drive(1'b1, 1'b1, DB + 6);

    // seven ups wrap through 0, then one down
    do_reset();
    for (int i = 0; i < 7; i++) begin
      press(1'b0, 1'b1);
      check_eq("up_seq", seg_data, exp_seq[i]);
    end
    press(1'b1, 1'b0);
    check_eq("down_wrap", seg_data, 6);

    // bounce: 2 low, 3 high, then a stable DB-cycle low
    s0 = n_steps;
    drive(1'b0, 1'b1, 2);
    drive(1'b1, 1'b1, 3);
    check_eq("glitch_hold", seg_data, 6);
    drive(1'b0, 1'b1, DB);
    drive(1'b1, 1'b1, DB + 6);
    check_eq("bounce_seg", seg_data, 0);
    check_eq("bounce_steps", n_steps - s0, 1);

    // simultaneous events
    s0 = n_steps;
    press(1'b0, 1'b0);
    check_eq("both_seg", seg_data, 0);
    check_eq("both_steps", n_steps - s0, 0);

    // idle blanking and wake-only press
    do_reset();
    repeat (3) press(1'b0, 1'b1);
    check_eq("idle_pre", seg_data, 3);
    drive(1'b1, 1'b1, IDLE + 5);
    check_eq("idle_blank", seg_data, 7);
    s0 = n_steps;
    press(1'b1, 1'b0);
    check_eq("wake_seg", seg_data, 3);
    check_eq("wake_steps", n_steps - s0, 0);
    press(1'b1, 1'b0);
    check_eq("after_wake", seg_data, 2);

    // reset during a debounce in progress
    do_reset();
    repeat (5) press(1'b0, 1'b1);
    check_eq("pre_rst", seg_data, 5);
    drive(1'b0, 1'b1, 4);
    rst = 1'b1;
    key_up_n = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_seg", seg_data, 0);
    check_eq("midrst_step", step_pulse, 0);
    @(negedge clk);
    rst = 1'b0;
    s0 = n_steps;
    drive(1'b1, 1'b1, DB + 10);
    check_eq("midrst_noev", seg_data, 0);
    check_eq("midrst_steps", n_steps - s0, 0);

    // random activity against the model
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 29) == 0) begin
        drive(1'b1, 1'b1, IDLE + $urandom_range(0, 10));
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
      end
    end
    drive(1'b1, 1'b1, DB + 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
